// File: rtl/mod_write_buffer.sv
// Posted-write buffer between the cache data-side SRAM request port and the SRAM controller.
// Writes are queued and drained in order; reads forward from the youngest matching entry or bypass to SRAM.
//
// state | meaning
// IDLE  | no SRAM request outstanding; pick a read miss first, else drain head
// WR    | head entry write in flight
// RD    | upstream read miss in flight
// GAP   | one mandatory idle cycle between SRAM requests
module mod_write_buffer #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             up_de,
   input  logic [1:0]       up_drw,
   input  logic [31:0]      up_addr,
   input  logic [31:0]      up_din,
   output logic [31:0]      up_dout,
   output logic             up_nrdy,
   output logic             mem_de,
   output logic [1:0]       mem_drw,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_din,
   input  logic [31:0]      mem_dout,
   input  logic             mem_nrdy,
   output logic             wb_empty,
   output logic [PTR_W:0]   wb_count,
   output logic             pmc_wb_stall
);

   typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_RD, ST_GAP} state_t;

   state_t             state_q, state_d;
   logic [29:0]        ent_addr_q [DEPTH];
   logic [29:0]        ent_addr_d [DEPTH];
   logic [31:0]        ent_data_q [DEPTH];
   logic [31:0]        ent_data_d [DEPTH];
   logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
   logic [PTR_W:0]     count_q, count_d;
   logic               empty_q, empty_d;
   logic               mem_de_q, mem_de_d;
   logic [1:0]         mem_drw_q, mem_drw_d;
   logic [31:0]        mem_addr_q, mem_addr_d;
   logic [31:0]        mem_din_q, mem_din_d;

   logic               is_wr, is_rd, full, push, pop, hit, rd_done;
   logic [31:0]        fwd_data;

   assign is_wr   = up_de && (up_drw == 2'b01);
   assign is_rd   = up_de && (up_drw == 2'b10);
   assign full    = (count_q == (PTR_W+1)'(DEPTH));
   assign push    = is_wr && !full && !rst;
   assign pop     = (state_q == ST_WR) && !mem_nrdy;
   assign rd_done = (state_q == ST_RD) && !mem_nrdy;

   // Youngest match wins: scan oldest to youngest and let later hits overwrite.
   always_comb begin
      logic [PTR_W-1:0] idx;
      hit      = 1'b0;
      fwd_data = '0;
      idx      = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head_q + PTR_W'(k);
         if (((PTR_W+1)'(k) < count_q) && (ent_addr_q[idx] == up_addr[31:2])) begin
            hit      = 1'b1;
            fwd_data = ent_data_q[idx];
         end
      end
   end

   always_comb begin
      up_nrdy      = 1'b0;
      up_dout      = '0;
      pmc_wb_stall = 1'b0;
      if (rst) begin
         up_nrdy = 1'b1;
      end else if (is_wr) begin
         up_nrdy      = full;
         pmc_wb_stall = full;
      end else if (is_rd) begin
         if (hit) begin
            up_dout = fwd_data;
         end else if (rd_done) begin
            up_dout = mem_dout;
         end else begin
            up_nrdy = 1'b1;
         end
      end
   end

   always_comb begin
      ent_addr_d = ent_addr_q;
      ent_data_d = ent_data_q;
      head_d     = head_q;
      tail_d     = tail_q;
      if (push) begin
         ent_addr_d[tail_q] = up_addr[31:2];
         ent_data_d[tail_q] = up_din;
         tail_d             = tail_q + 1'b1;
      end
      if (pop) begin
         head_d = head_q + 1'b1;
      end
      count_d = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
      empty_d = (count_d == '0);
   end

   always_comb begin
      state_d    = state_q;
      mem_de_d   = mem_de_q;
      mem_drw_d  = mem_drw_q;
      mem_addr_d = mem_addr_q;
      mem_din_d  = mem_din_q;
      case (state_q)
         ST_IDLE: begin
            if (is_rd && !hit) begin
               state_d    = ST_RD;
               mem_de_d   = 1'b1;
               mem_drw_d  = 2'b10;
               mem_addr_d = up_addr;
            end else if (!empty_q) begin
               state_d    = ST_WR;
               mem_de_d   = 1'b1;
               mem_drw_d  = 2'b01;
               mem_addr_d = {ent_addr_q[head_q], 2'b00};
               mem_din_d  = ent_data_q[head_q];
            end
         end
         ST_WR, ST_RD: begin
            if (!mem_nrdy) begin
               state_d  = ST_GAP;
               mem_de_d = 1'b0;
            end
         end
         ST_GAP:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         empty_q    <= 1'b1;
         mem_de_q   <= 1'b0;
         mem_drw_q  <= 2'b00;
         mem_addr_q <= '0;
         mem_din_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ent_addr_q[i] <= '0;
            ent_data_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         empty_q    <= empty_d;
         mem_de_q   <= mem_de_d;
         mem_drw_q  <= mem_drw_d;
         mem_addr_q <= mem_addr_d;
         mem_din_q  <= mem_din_d;
         ent_addr_q <= ent_addr_d;
         ent_data_q <= ent_data_d;
      end
   end

   assign mem_de   = mem_de_q;
   assign mem_drw  = mem_drw_q;
   assign mem_addr = mem_addr_q;
   assign mem_din  = mem_din_q;
   assign wb_empty = empty_q;
   assign wb_count = count_q;

endmodule

// File: tb/tb_mod_write_buffer.sv
// Directed bench for mod_write_buffer: reset, drain timing, full stall, forwarding, read bypass, reset mid-drain.
module tb_mod_write_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        up_de;
   logic [1:0]  up_drw;
   logic [31:0] up_addr, up_din, up_dout;
   logic        up_nrdy;
   logic        mem_de;
   logic [1:0]  mem_drw;
   logic [31:0] mem_addr, mem_din, mem_dout;
   logic        mem_nrdy;
   logic        wb_empty;
   logic [2:0]  wb_count;
   logic        pmc_wb_stall;

   int n_chk  = 0;
   int n_pass = 0;
   int rd_cnt = 0;
   int rd_base;

   mod_write_buffer #(.DEPTH(4), .PTR_W(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .up_de        (up_de),
      .up_drw       (up_drw),
      .up_addr      (up_addr),
      .up_din       (up_din),
      .up_dout      (up_dout),
      .up_nrdy      (up_nrdy),
      .mem_de       (mem_de),
      .mem_drw      (mem_drw),
      .mem_addr     (mem_addr),
      .mem_din      (mem_din),
      .mem_dout     (mem_dout),
      .mem_nrdy     (mem_nrdy),
      .wb_empty     (wb_empty),
      .wb_count     (wb_count),
      .pmc_wb_stall (pmc_wb_stall)
   );

   always #5 clk = ~clk;

   // SRAM read requests seen, sampled mid-cycle.
   always @(negedge clk) if (mem_de === 1'b1 && mem_drw === 2'b10) rd_cnt++;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic [1:0] drw, input logic [31:0] a, input logic [31:0] d);
      up_de   = 1'b1;
      up_drw  = drw;
      up_addr = a;
      up_din  = d;
      #1;
   endtask

   task automatic idle_up();
      up_de  = 1'b0;
      up_drw = 2'b00;
   endtask

   // Wait (bounded) for the next SRAM write, check it, complete it in one cycle.
   task automatic drain_one(input string tag, input logic [31:0] ea, input logic [31:0] ed);
      int n = 0;
      while (mem_de !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_de"},   mem_de,   1);
      check({tag, "_drw"},  mem_drw,  2'b01);
      check({tag, "_addr"}, mem_addr, ea);
      check({tag, "_din"},  mem_din,  ed);
      mem_nrdy = 1'b0;
      tick();
      mem_nrdy = 1'b1;
   endtask

   initial begin
      rst = 1'b1; up_de = 1'b0; up_drw = 2'b00; up_addr = '0; up_din = '0;
      mem_dout = '0; mem_nrdy = 1'b1;

      // 1. reset
      tick(); tick();
      check("rst_nrdy",  up_nrdy,  1);
      check("rst_dout",  up_dout,  0);
      check("rst_empty", wb_empty, 1);
      check("rst_count", wb_count, 0);
      check("rst_mem_de", mem_de,  0);
      check("rst_drw",   mem_drw,  0);
      check("rst_stall", pmc_wb_stall, 0);
      rst = 1'b0;
      tick();

      // 2. single write, 5 busy cycles
      req(2'b01, 32'h1000, 32'hDEADBEEF);
      check("w1_nrdy", up_nrdy, 0);
      tick(); idle_up(); #1;
      check("w1_count", wb_count, 1);
      check("w1_empty", wb_empty, 0);
      tick();
      check("w1_de",   mem_de,   1);
      check("w1_drw",  mem_drw,  2'b01);
      check("w1_addr", mem_addr, 32'h1000);
      check("w1_din",  mem_din,  32'hDEADBEEF);
      for (int i = 0; i < 4; i++) tick();
      check("w1_hold", mem_de, 1);
      mem_nrdy = 1'b0;
      tick(); mem_nrdy = 1'b1;
      check("w1_cnt0",  wb_count, 0);
      check("w1_emp1",  wb_empty, 1);
      check("w1_gap",   mem_de,   0);
      tick();
      check("w1_gap2",  mem_de,   0);

      // 3. fill to full, stall, then release
      req(2'b01, 32'h100, 32'hA0); check("f0_nrdy", up_nrdy, 0); tick();
      req(2'b01, 32'h104, 32'hA1); check("f1_nrdy", up_nrdy, 0); tick();
      req(2'b01, 32'h108, 32'hA2); check("f2_nrdy", up_nrdy, 0); tick();
      req(2'b01, 32'h10C, 32'hA3); check("f3_nrdy", up_nrdy, 0); tick();
      req(2'b01, 32'h110, 32'hA4);
      check("full_count", wb_count, 4);
      check("full_nrdy",  up_nrdy,  1);
      check("full_stall", pmc_wb_stall, 1);
      check("a0_addr", mem_addr, 32'h100);
      check("a0_din",  mem_din,  32'hA0);
      mem_nrdy = 1'b0; #1;
      check("pop_nrdy", up_nrdy, 1);
      tick(); mem_nrdy = 1'b1; #1;
      check("after_pop_nrdy",  up_nrdy, 0);
      check("after_pop_stall", pmc_wb_stall, 0);
      check("after_pop_count", wb_count, 3);
      tick(); idle_up();
      check("a4_count", wb_count, 4);
      drain_one("a1", 32'h104, 32'hA1);
      drain_one("a2", 32'h108, 32'hA2);
      drain_one("a3", 32'h10C, 32'hA3);
      drain_one("a4", 32'h110, 32'hA4);
      check("fill_end_count", wb_count, 0);
      tick();

      // 4. forward youngest match, no SRAM read
      rd_base = rd_cnt;
      req(2'b01, 32'h2000, 32'h1); tick();
      req(2'b01, 32'h2000, 32'h2); tick();
      req(2'b10, 32'h2000, 32'h0);
      check("fwd_nrdy", up_nrdy, 0);
      check("fwd_dout", up_dout, 32'h2);
      tick(); idle_up();
      drain_one("dup1", 32'h2000, 32'h1);
      drain_one("dup2", 32'h2000, 32'h2);
      check("fwd_no_rd", rd_cnt - rd_base, 0);
      tick();

      // 5. read miss bypasses the queued write
      rd_base = rd_cnt;
      req(2'b01, 32'h3004, 32'h11); tick();
      req(2'b01, 32'h3008, 32'h22); tick();
      req(2'b10, 32'h3000, 32'h0);
      check("byp_nrdy0", up_nrdy, 1);
      check("byp_head",  mem_addr, 32'h3004);
      mem_nrdy = 1'b0;
      tick(); mem_nrdy = 1'b1;
      check("byp_gap_de",   mem_de,  0);
      check("byp_gap_nrdy", up_nrdy, 1);
      tick();
      check("byp_idle_de",  mem_de,  0);
      tick();
      check("byp_rd_de",   mem_de,   1);
      check("byp_rd_drw",  mem_drw,  2'b10);
      check("byp_rd_addr", mem_addr, 32'h3000);
      check("byp_count",   wb_count, 1);
      mem_dout = 32'hCAFEF00D; mem_nrdy = 1'b0; #1;
      check("byp_done_nrdy", up_nrdy, 0);
      check("byp_done_dout", up_dout, 32'hCAFEF00D);
      tick(); mem_nrdy = 1'b1; idle_up();
      drain_one("byp_w2", 32'h3008, 32'h22);
      check("byp_one_rd", rd_cnt - rd_base, 1);
      tick();

      // 6. reset mid-drain
      req(2'b01, 32'h4000, 32'h1); tick();
      req(2'b01, 32'h4004, 32'h2); tick();
      req(2'b01, 32'h4008, 32'h3); tick();
      idle_up();
      check("md_count", wb_count, 3);
      check("md_de",    mem_de,   1);
      rst = 1'b1; #1;
      check("md_rst_nrdy", up_nrdy, 1);
      tick();
      check("md_count0", wb_count, 0);
      check("md_empty",  wb_empty, 1);
      check("md_de0",    mem_de,   0);
      rst = 1'b0;
      tick();
      check("md_post_de",   mem_de,  0);
      check("md_post_nrdy", up_nrdy, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
